mu0_control: RTL
================

// Module: mu0_control
// PURPOSE
//  Control FSM for the MU0 12-bit-address processor. Sequences the shared datapath (PC, IR, ACC, ALU,
//  address/operand muxes) through FETCH and EXECUTE phases and drives the memory request lines.
//  Decodes the 4-bit opcode F = IR[15:12] and the ACC flags N/Z. Sits beside mu0_datapath inside mu0.
// PARAMETERS
//  ALU_FS_W   2   width of ALU function select (fixed encoding below; do not change)
// PORTS
//  clk       in   1  system clock; all state changes on rising edge
//  reset     in   1  synchronous, active-high reset
//  F         in   4  opcode from IR[15:12]
//  N         in   1  ACC negative flag (ACC[15])
//  Z         in   1  ACC zero flag (ACC==0)
//  mem_ready in   1  memory done strobe; used only with MU0_MEMWAIT_EN
//  addr_sel  out  1  address mux: 0=PC, 1=IR[11:0]
//  x_sel     out  1  ALU X mux: 0=ACC, 1=PC
//  y_sel     out  1  ALU Y mux: 0=memory Din, 1=IR[11:0]
//  alu_fs    out  2  00=Y, 01=X+Y, 10=X+1, 11=X-Y
//  acc_ce    out  1  ACC load enable
//  pc_ce     out  1  PC load enable
//  ir_ce     out  1  IR load enable
//  acc_oe    out  1  ACC drives memory Dout
//  mem_rq    out  1  memory request
//  rnw       out  1  1=read, 0=write (valid when mem_rq=1)
//  fetch     out  1  high while in FETCH state (debug/trace)
//  halted    out  1  high in HALT state
// BEHAVIOUR
//  States: FETCH, EXECUTE, HALT (2-bit register). Outputs are combinational from state, F, N, Z, mem_ready.
//  Reset: reset=1 at rising edge -> state=FETCH. While reset=1, every output is forced 0 (incl. fetch, halted).
//   Reset mid-instruction aborts it; no ACC/PC/IR enable fires in that cycle.
//  FETCH: addr_sel=0, mem_rq=1, rnw=1, ir_ce=1, x_sel=1, alu_fs=10, pc_ce=1 (PC<=PC+1), fetch=1 -> EXECUTE.
//  EXECUTE, by F (then -> FETCH unless noted):
//   0 LDA: addr_sel=1, mem_rq=1, rnw=1, y_sel=0, alu_fs=00, acc_ce=1
//   1 STA: addr_sel=1, mem_rq=1, rnw=0, acc_oe=1
//   2 ADD: addr_sel=1, mem_rq=1, rnw=1, x_sel=0, y_sel=0, alu_fs=01, acc_ce=1
//   3 SUB: as ADD with alu_fs=11
//   4 JMP: y_sel=1, alu_fs=00, pc_ce=1
//   5 JGE: as JMP iff N=0, else no enables
//   6 JNE: as JMP iff Z=0, else no enables
//   7 STP: no enables -> HALT
//   8-F : reserved, executed as NOP (no enables, no mem_rq) -> FETCH
//  HALT: halted=1, all other outputs 0; remains until reset.
//  Unused mux selects/alu_fs default 0; rnw defaults 1. Without wait states CPI=2 (STP enters HALT after 2).
//  N/Z sampled combinationally in EXECUTE; they reflect ACC before any update in that cycle.
// CONFIGURATION
//  MU0_MEMWAIT_EN defined: any state asserting mem_rq holds (no transition) while mem_ready=0; mem_rq,
//   rnw, addr_sel, acc_oe stay asserted; acc_ce/pc_ce/ir_ce forced 0 until mem_ready=1, then asserted
//   for exactly that cycle and state advances. Non-memory states ignore mem_ready. Reset overrides wait.
//  MU0_MEMWAIT_EN undefined: mem_ready ignored (treated as 1); every state lasts one cycle.
// TESTING
//  1 reset=1 two cycles, then 0 -> all outputs 0 during reset; first cycle after: fetch=1, ir_ce=1, pc_ce=1, alu_fs=10.
//  2 EXECUTE with F=0,2,3,1 -> LDA: acc_ce=1,alu_fs=00; ADD: alu_fs=01; SUB: alu_fs=11; STA: rnw=0,acc_oe=1,acc_ce=0.
//  3 F=5 with N=1 then N=0; F=6 with Z=1 then Z=0 -> pc_ce=0,1,0,1 respectively; y_sel=1 when taken.
//  4 F=7 -> halted=1 next cycle, stays 1 for 20 cycles with any F; reset=1 -> FETCH on next edge.
//  5 F=4'hA -> no enables, no mem_rq, fetch=1 next cycle.
//  6 MU0_MEMWAIT_EN: FETCH with mem_ready=0 for 3 cycles -> mem_rq=1, ir_ce=0, state held; mem_ready=1 -> ir_ce=pc_ce=1, EXECUTE next;
//    assert reset during wait -> FETCH, outputs 0.

Source files
------------

// File: rtl/mu0_control.sv
// ---------------------------------------------------------------------------
// mu0_control
//   Control FSM for the MU0 processor (16-bit instruction, 12-bit address).
//   It steps the shared datapath (PC, IR, ACC, ALU, address and operand muxes)
//   through FETCH and EXECUTE phases and drives the memory request lines.
//   The opcode F is IR[15:12]. N and Z are the ACC flags.
//
//   Optional feature: define MU0_MEMWAIT_EN to make memory states wait for
//   mem_ready. Without it, mem_ready is ignored and every state takes one
//   cycle, so CPI is 2.
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   synchronous, active-high reset (state goes to FETCH)
//   F[3:0]     in   opcode from IR[15:12]
//   N          in   ACC negative flag (ACC[15])
//   Z          in   ACC zero flag (ACC == 0)
//   mem_ready  in   memory done strobe (used only with MU0_MEMWAIT_EN)
//   addr_sel   out  address mux: 0 = PC, 1 = IR[11:0]
//   x_sel      out  ALU X mux: 0 = ACC, 1 = PC
//   y_sel      out  ALU Y mux: 0 = memory Din, 1 = IR[11:0]
//   alu_fs     out  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y
//   acc_ce     out  ACC load enable
//   pc_ce      out  PC load enable
//   ir_ce      out  IR load enable
//   acc_oe     out  ACC drives memory Dout
//   mem_rq     out  memory request
//   rnw        out  1 = read, 0 = write (meaningful while mem_rq = 1)
//   fetch      out  high in the FETCH state (trace)
//   halted     out  high in the HALT state
// ---------------------------------------------------------------------------
module mu0_control #(
  parameter int ALU_FS_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          F,
  input  logic                N,
  input  logic                Z,
  input  logic                mem_ready,
  output logic                addr_sel,
  output logic                x_sel,
  output logic                y_sel,
  output logic [ALU_FS_W-1:0] alu_fs,
  output logic                acc_ce,
  output logic                pc_ce,
  output logic                ir_ce,
  output logic                acc_oe,
  output logic                mem_rq,
  output logic                rnw,
  output logic                fetch,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_HALT    = 2'b10
  } state_t;

  localparam logic [ALU_FS_W-1:0] FS_Y    = 2'b00;
  localparam logic [ALU_FS_W-1:0] FS_ADD  = 2'b01;
  localparam logic [ALU_FS_W-1:0] FS_INC  = 2'b10;
  localparam logic [ALU_FS_W-1:0] FS_SUB  = 2'b11;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  state_t state, state_nxt;

  // High while a memory access is outstanding and the state must hold.
  logic mem_wait;

`ifdef MU0_MEMWAIT_EN
  assign mem_wait = mem_rq & ~mem_ready;
`else
  assign mem_wait = 1'b0;
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    addr_sel  = 1'b0;
    x_sel     = 1'b0;
    y_sel     = 1'b0;
    alu_fs    = FS_Y;
    acc_ce    = 1'b0;
    pc_ce     = 1'b0;
    ir_ce     = 1'b0;
    acc_oe    = 1'b0;
    mem_rq    = 1'b0;
    rnw       = 1'b1;
    fetch     = 1'b0;
    halted    = 1'b0;
    state_nxt = state;

    unique case (state)
      S_FETCH: begin
        // Read the instruction at PC into IR, and increment PC through the ALU.
        addr_sel  = 1'b0;
        mem_rq    = 1'b1;
        rnw       = 1'b1;
        ir_ce     = 1'b1;
        x_sel     = 1'b1;
        alu_fs    = FS_INC;
        pc_ce     = 1'b1;
        fetch     = 1'b1;
        state_nxt = S_EXECUTE;
      end

      S_EXECUTE: begin
        state_nxt = S_FETCH;
        case (F)
          OP_LDA: begin
            addr_sel = 1'b1;
            mem_rq   = 1'b1;
            rnw      = 1'b1;
            y_sel    = 1'b0;
            alu_fs   = FS_Y;
            acc_ce   = 1'b1;
          end
          OP_STA: begin
            addr_sel = 1'b1;
            mem_rq   = 1'b1;
            rnw      = 1'b0;
            acc_oe   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            addr_sel = 1'b1;
            mem_rq   = 1'b1;
            rnw      = 1'b1;
            x_sel    = 1'b0;
            y_sel    = 1'b0;
            alu_fs   = (F == OP_SUB) ? FS_SUB : FS_ADD;
            acc_ce   = 1'b1;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            // The flags show ACC as it is now. No instruction changes ACC
            // in the same cycle as a jump, so no forwarding is needed.
            if ((F == OP_JMP) || (F == OP_JGE && !N) || (F == OP_JNE && !Z)) begin
              y_sel  = 1'b1;
              alu_fs = FS_Y;
              pc_ce  = 1'b1;
            end
          end
          OP_STP: begin
            state_nxt = S_HALT;
          end
          default: begin
            // Reserved opcodes behave as NOP: nothing is enabled and no memory
            // request is made.
          end
        endcase
      end

      S_HALT: begin
        halted    = 1'b1;
        rnw       = 1'b0;
        state_nxt = S_HALT;
      end

      default: begin
        // The unused encoding 2'b11 recovers to FETCH.
        rnw       = 1'b0;
        state_nxt = S_FETCH;
      end
    endcase

    // Wait state: keep the request lines and muxes asserted, and hold the
    // register enables and the state until memory is ready.
    if (mem_wait) begin
      acc_ce    = 1'b0;
      pc_ce     = 1'b0;
      ir_ce     = 1'b0;
      state_nxt = state;
    end

    // Reset overrides everything. No enable can fire in a cycle that is
    // being aborted.
    if (reset) begin
      addr_sel = 1'b0;
      x_sel    = 1'b0;
      y_sel    = 1'b0;
      alu_fs   = FS_Y;
      acc_ce   = 1'b0;
      pc_ce    = 1'b0;
      ir_ce    = 1'b0;
      acc_oe   = 1'b0;
      mem_rq   = 1'b0;
      rnw      = 1'b0;
      fetch    = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule
